lfsr_rr_server: RTL and testbench

- Shares one 4-bit Fibonacci LFSR pseudo-random source among NREQ requesters.
- Arbitration is round-robin; each grant hands out exactly one fresh LFSR value.
- Controls sequencing of the source:
  - warm-up after reset or reseed;
  - runtime seed load, with zero-seed protection;
  - advancing the LFSR only on consumption, so the sequence is deterministic per grant.
- Sits between the shared random source and consumers such as scramblers, test-pattern generators and randomized-backoff logic.

---
 rtl/lfsr_rr_server.sv | 137 +++++++++++++
 tb/tb_lfsr_rr_server.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_server.sv
// -----------------------------------------------------------------------------
// lfsr_rr_server
// Shares one Fibonacci LFSR among NREQ requesters. A round-robin arbiter picks
// one requester per cycle. Each grant hands out the current LFSR value, and
// only then is the LFSR stepped. The sequence per grant is therefore
// deterministic: it does not depend on idle cycles.
// After reset or a reseed, WARMUP LFSR steps are discarded before serving.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   req        in   [NREQ]  per-requester request level
//   seed_load  in   one-cycle pulse, load seed_val (zero maps to SEED)
//   seed_val   in   [WIDTH] new seed
//   gnt        out  [NREQ]  registered one-hot grant pulse
//   rnd_valid  out  high whenever gnt is nonzero
//   rnd_data   out  [WIDTH] value for the granted requester, held after gnt
//   ready      out  high while serving
// -----------------------------------------------------------------------------
module lfsr_rr_server #(
   parameter int               NREQ   = 4,
   parameter int               WIDTH  = 4,
   parameter logic [WIDTH-1:0] TAPS   = 4'hC,
   parameter logic [WIDTH-1:0] SEED   = 4'hF,
   parameter int               WARMUP = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_val,
   output logic [NREQ-1:0]  gnt,
   output logic             rnd_valid,
   output logic [WIDTH-1:0] rnd_data,
   output logic             ready
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      WARMUP_S = 1'b0,
      SERVE_S  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] lfsr_reg, lfsr_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [LW-1:0]    last_reg, last_next;
   logic [NREQ-1:0]  gnt_reg, gnt_next;
   logic [WIDTH-1:0] rnd_data_reg, rnd_data_next;
   logic             ready_reg;

   logic [WIDTH-1:0] lfsr_step;
   logic             found;
   logic [LW-1:0]    winner;
   logic [LW-1:0]    cand;

   assign lfsr_step = {lfsr_reg[WIDTH-2:0], ^(lfsr_reg & TAPS)};

   // Round-robin search: scan last+1, last+2, ... (mod NREQ). The previous
   // winner comes last, so a lone continuous requester still wins every cycle.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = LW'((int'(last_reg) + k) % NREQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      lfsr_next     = lfsr_reg;
      cnt_next      = cnt_reg;
      last_next     = last_reg;
      gnt_next      = '0;
      rnd_data_next = rnd_data_reg;

      if (seed_load) begin
         // A reseed wins over a grant on the same edge. A zero seed would
         // lock up the LFSR, so SEED is loaded in its place.
         lfsr_next  = (seed_val == '0) ? SEED : seed_val;
         cnt_next   = 4'(WARMUP);
         state_next = WARMUP_S;
      end else begin
         case (state_reg)
            WARMUP_S: begin
               if (cnt_reg != 4'd0) begin
                  lfsr_next = lfsr_step;
                  cnt_next  = cnt_reg - 4'd1;
               end else begin
                  state_next = SERVE_S;
               end
            end
            SERVE_S: begin
               if (found) begin
                  gnt_next[winner] = 1'b1;
                  rnd_data_next    = lfsr_reg;
                  lfsr_next        = lfsr_step;
                  last_next        = winner;
               end
            end
            default: state_next = WARMUP_S;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= WARMUP_S;
         lfsr_reg     <= SEED;
         cnt_reg      <= 4'(WARMUP);
         last_reg     <= LW'(NREQ - 1);
         gnt_reg      <= '0;
         rnd_data_reg <= '0;
         ready_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lfsr_reg     <= lfsr_next;
         cnt_reg      <= cnt_next;
         last_reg     <= last_next;
         gnt_reg      <= gnt_next;
         rnd_data_reg <= rnd_data_next;
         ready_reg    <= (state_next == SERVE_S);
      end
   end

   assign gnt       = gnt_reg;
   assign rnd_valid = |gnt_reg;
   assign rnd_data  = rnd_data_reg;
   assign ready     = ready_reg;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// -----------------------------------------------------------------------------
// Testbench for lfsr_rr_server with its default parameters.
// The stimulus process pushes the expected {gnt, rnd_data} for every edge that
// should grant. The monitor pops an entry at each falling edge where rnd_valid
// is high and compares it with the DUT outputs. The stimulus process also
// checks ready, the reset values and the held rnd_data directly.
// -----------------------------------------------------------------------------
module tb_lfsr_rr_server;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = '0;
   logic       seed_load = 1'b0;
   logic [3:0] seed_val = '0;
   logic [3:0] gnt;
   logic       rnd_valid;
   logic [3:0] rnd_data;
   logic       ready;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];

   lfsr_rr_server dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .seed_load (seed_load),
      .seed_val  (seed_val),
      .gnt       (gnt),
      .rnd_valid (rnd_valid),
      .rnd_data  (rnd_data),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: one line per grant observed.
   always @(negedge clk) begin
      if (rnd_valid === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_grant: got gnt=%b data=%h, expected no grant", gnt, rnd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if ({gnt, rnd_data} !== e) begin
               miscompares++;
               $display("FAIL grant: got gnt=%b data=%h, expected gnt=%b data=%h",
                        gnt, rnd_data, e[7:4], e[3:0]);
            end else begin
               $display("grant gnt=%b data=%h ok", gnt, rnd_data);
            end
         end
      end
   end

   // Drive one edge. A nonzero eg means this edge must grant eg with data ed.
   task automatic step_cycle(input logic [3:0] r, input logic [3:0] eg, input logic [3:0] ed);
      req = r;
      if (eg != 4'd0) exp_q.push_back({eg, ed});
      @(posedge clk);
      #1;
   endtask

   // Reset with req held, then run the warm-up edges and check ready timing.
   task automatic do_reset(input logic [3:0] r);
      reset = 1'b1;
      req = r;
      seed_load = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_gnt", {4'd0, gnt}, 8'h00);
      chk("reset_data", {4'd0, rnd_data}, 8'h00);
      chk("reset_ready", {7'd0, ready}, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step_cycle(r, 4'd0, 4'd0);
         chk("warmup_ready", {7'd0, ready}, (i == 3) ? 8'h01 : 8'h00);
      end
   endtask

   // Reseed while req is held, then check the warm-up with no grants.
   task automatic reseed(input logic [3:0] sv, input logic [3:0] r);
      seed_val = sv;
      seed_load = 1'b1;
      step_cycle(r, 4'd0, 4'd0);
      seed_load = 1'b0;
      chk("seed_ready_drop", {7'd0, ready}, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step_cycle(r, 4'd0, 4'd0);
         chk("seed_warmup_ready", {7'd0, ready}, (i == 3) ? 8'h01 : 8'h00);
      end
   endtask

   initial begin
      logic [3:0] seq1 [6];
      seq1 = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3};

      // Single requester: grants every cycle from edge 5.
      do_reset(4'b0001);
      for (int i = 0; i < 6; i++) step_cycle(4'b0001, 4'b0001, seq1[i]);

      // Round-robin over all requesters from a fresh reset.
      do_reset(4'b1111);
      step_cycle(4'b1111, 4'b0001, 4'h8);
      step_cycle(4'b1111, 4'b0010, 4'h1);
      step_cycle(4'b1111, 4'b0100, 4'h2);
      step_cycle(4'b1111, 4'b1000, 4'h4);
      step_cycle(4'b1111, 4'b0001, 4'h9);

      // Sparse requests alternate. An idle gap holds the LFSR and rnd_data.
      step_cycle(4'b1010, 4'b0010, 4'h3);
      step_cycle(4'b1010, 4'b1000, 4'h6);
      step_cycle(4'b1010, 4'b0010, 4'hD);
      step_cycle(4'b1010, 4'b1000, 4'hA);
      for (int i = 0; i < 3; i++) begin
         step_cycle(4'b0000, 4'd0, 4'd0);
         chk("idle_data_hold", {4'd0, rnd_data}, 8'h0A);
         chk("idle_gnt", {4'd0, gnt}, 8'h00);
      end
      step_cycle(4'b1010, 4'b0010, 4'h5);
      step_cycle(4'b1010, 4'b1000, 4'hB);

      // Reseed with 1 on the same edge as req: no grant, warm-up 1->2->4->9.
      reseed(4'h1, 4'b1111);
      step_cycle(4'b1111, 4'b0001, 4'h9);
      step_cycle(4'b1111, 4'b0010, 4'h3);

      // A zero seed is replaced by SEED: the first grant returns 8.
      reseed(4'h0, 4'b0001);
      step_cycle(4'b0001, 4'b0001, 4'h8);
      step_cycle(4'b0001, 4'b0001, 4'h1);

      // Reset in the middle of a grant stream, then the sequence restarts.
      do_reset(4'b0001);
      step_cycle(4'b0001, 4'b0001, 4'h8);
      step_cycle(4'b0001, 4'b0001, 4'h1);
      step_cycle(4'b0000, 4'd0, 4'd0);

      @(negedge clk);
      chk("queue_drained", 8'(exp_q.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
